// File: rtl/decode_pipe.sv
// Decode-stage register file and D->E pipeline register.
// Implements write-first reads, load-use stall and flush/hold control.
module decode_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned CTRLW = 16,
    parameter int unsigned LDBIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_valid,
    input  logic [31:0]      d_instr,
    input  logic [XLEN-1:0]  d_pc,
    input  logic [CTRLW-1:0] d_ctrl,
    input  logic [XLEN-1:0]  d_imm,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             e_hold,
    input  logic             e_flush,
    output logic             e_valid,
    output logic [CTRLW-1:0] e_ctrl,
    output logic [XLEN-1:0]  e_pc,
    output logic [XLEN-1:0]  e_r1,
    output logic [XLEN-1:0]  e_r2,
    output logic [XLEN-1:0]  e_imm,
    output logic [4:0]       e_rd,
    output logic [4:0]       e_rs1,
    output logic [4:0]       e_rs2,
    output logic             stall_d,
    output logic             illegal_reg_d
);

    localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;

    function automatic logic in_range(input logic [4:0] idx);
        return 32'(idx) < NREG;
    endfunction

    logic [XLEN-1:0] rf_q [NREG];

    logic [4:0]      rs1, rs2, rd;
    logic            wb_ok;
    logic [XLEN-1:0] rdata1, rdata2;
    logic            load_use;

    assign rs1   = d_instr[19:15];
    assign rs2   = d_instr[24:20];
    assign rd    = d_instr[11:7];
    assign wb_ok = wb_we && (wb_rd != 5'd0) && in_range(wb_rd);

    // Out-of-range and x0 reads return zero; a matching writeback bypasses the array.
    always_comb begin
        rdata1 = '0;
        if (rs1 != 5'd0 && in_range(rs1)) begin
            rdata1 = (wb_ok && wb_rd == rs1) ? wb_data : rf_q[rs1[RW-1:0]];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rs2 != 5'd0 && in_range(rs2)) begin
            rdata2 = (wb_ok && wb_rd == rs2) ? wb_data : rf_q[rs2[RW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_ok) begin
            rf_q[wb_rd[RW-1:0]] <= wb_data;
        end
    end

    logic             e_valid_q, e_valid_d;
    logic [CTRLW-1:0] e_ctrl_q, e_ctrl_d;
    logic [XLEN-1:0]  e_pc_q, e_pc_d;
    logic [XLEN-1:0]  e_r1_q, e_r1_d;
    logic [XLEN-1:0]  e_r2_q, e_r2_d;
    logic [XLEN-1:0]  e_imm_q, e_imm_d;
    logic [4:0]       e_rd_q, e_rd_d;
    logic [4:0]       e_rs1_q, e_rs1_d;
    logic [4:0]       e_rs2_q, e_rs2_d;

    assign load_use = e_valid_q && e_ctrl_q[LDBIT] && (e_rd_q != 5'd0) && d_valid &&
                      ((e_rd_q == rs1) || (e_rd_q == rs2));

    assign stall_d       = load_use || e_hold;
    assign illegal_reg_d = d_valid && (!in_range(rs1) || !in_range(rs2));

    // Flush and bubble both load data fields; only valid/ctrl are killed.
    always_comb begin
        e_valid_d = e_valid_q;
        e_ctrl_d  = e_ctrl_q;
        e_pc_d    = e_pc_q;
        e_r1_d    = e_r1_q;
        e_r2_d    = e_r2_q;
        e_imm_d   = e_imm_q;
        e_rd_d    = e_rd_q;
        e_rs1_d   = e_rs1_q;
        e_rs2_d   = e_rs2_q;
        if (e_flush || !e_hold) begin
            e_pc_d  = d_pc;
            e_r1_d  = rdata1;
            e_r2_d  = rdata2;
            e_imm_d = d_imm;
            e_rd_d  = rd;
            e_rs1_d = rs1;
            e_rs2_d = rs2;
            if (e_flush || load_use) begin
                e_valid_d = 1'b0;
                e_ctrl_d  = '0;
            end else begin
                e_valid_d = d_valid;
                e_ctrl_d  = d_valid ? d_ctrl : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_valid_q <= 1'b0;
            e_ctrl_q  <= '0;
            e_pc_q    <= '0;
            e_r1_q    <= '0;
            e_r2_q    <= '0;
            e_imm_q   <= '0;
            e_rd_q    <= '0;
            e_rs1_q   <= '0;
            e_rs2_q   <= '0;
        end else begin
            e_valid_q <= e_valid_d;
            e_ctrl_q  <= e_ctrl_d;
            e_pc_q    <= e_pc_d;
            e_r1_q    <= e_r1_d;
            e_r2_q    <= e_r2_d;
            e_imm_q   <= e_imm_d;
            e_rd_q    <= e_rd_d;
            e_rs1_q   <= e_rs1_d;
            e_rs2_q   <= e_rs2_d;
        end
    end

    assign e_valid = e_valid_q;
    assign e_ctrl  = e_ctrl_q;
    assign e_pc    = e_pc_q;
    assign e_r1    = e_r1_q;
    assign e_r2    = e_r2_q;
    assign e_imm   = e_imm_q;
    assign e_rd    = e_rd_q;
    assign e_rs1   = e_rs1_q;
    assign e_rs2   = e_rs2_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: one RV32I instance and one RV32E (NREG=16) instance
// sharing the same stimulus.
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_valid;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [15:0] d_ctrl;
    logic [31:0] d_imm;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        e_hold;
    logic        e_flush;

    logic        a_valid, b_valid;
    logic [15:0] a_ctrl, b_ctrl;
    logic [31:0] a_pc, a_r1, a_r2, a_imm, b_pc, b_r1, b_r2, b_imm;
    logic [4:0]  a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;
    logic        a_stall, a_ill, b_stall, b_ill;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    decode_pipe u_dut32 (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc),
        .d_ctrl(d_ctrl), .d_imm(d_imm), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .e_hold(e_hold), .e_flush(e_flush), .e_valid(a_valid), .e_ctrl(a_ctrl), .e_pc(a_pc),
        .e_r1(a_r1), .e_r2(a_r2), .e_imm(a_imm), .e_rd(a_rd), .e_rs1(a_rs1), .e_rs2(a_rs2),
        .stall_d(a_stall), .illegal_reg_d(a_ill)
    );

    decode_pipe #(.NREG(16)) u_dut16 (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc),
        .d_ctrl(d_ctrl), .d_imm(d_imm), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .e_hold(e_hold), .e_flush(e_flush), .e_valid(b_valid), .e_ctrl(b_ctrl), .e_pc(b_pc),
        .e_r1(b_r1), .e_r2(b_r2), .e_imm(b_imm), .e_rd(b_rd), .e_rs1(b_rs1), .e_rs2(b_rs2),
        .stall_d(b_stall), .illegal_reg_d(b_ill)
    );

    function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'b0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; d_valid = 1'b0; d_instr = '0; d_pc = '0; d_ctrl = '0; d_imm = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0; e_hold = 1'b0; e_flush = 1'b0;

        #7;
        check("rst_valid", a_valid, 1'b0);
        check("rst_pc", a_pc, 32'h0);
        check("rst_stall", a_stall, 1'b0);
        #1 rst = 1'b1;

        // Write x5, then ADD x6,x5,x0
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        wb_we = 1'b0;
        d_valid = 1'b1; d_instr = r_add(5'd6, 5'd5, 5'd0); d_pc = 32'h100;
        d_ctrl = 16'h0002; d_imm = 32'h11;
        tick();
        check("add_valid", a_valid, 1'b1);
        check("add_r1", a_r1, 32'hDEADBEEF);
        check("add_r2_x0", a_r2, 32'h0);
        check("add_rd", a_rd, 5'd6);
        check("add_pc", a_pc, 32'h100);
        check("add_ctrl", a_ctrl, 16'h0002);
        check("add_imm", a_imm, 32'h11);

        // Same-cycle writeback bypass on x7
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h12345678;
        d_instr = r_add(5'd8, 5'd7, 5'd5); d_ctrl = 16'h0004;
        tick();
        check("bypass_r1", a_r1, 32'h12345678);
        check("bypass_r2", a_r2, 32'hDEADBEEF);
        check("bypass_rd", a_rd, 5'd8);

        // Write to x0 is neither stored nor forwarded
        wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        d_instr = r_add(5'd9, 5'd0, 5'd7);
        tick();
        check("x0_r1", a_r1, 32'h0);
        check("x7_r2", a_r2, 32'h12345678);

        // Load-use: LW x3 in E, ADD x4,x3,x1 in D
        wb_we = 1'b0;
        d_instr = i_lw(5'd3, 5'd1); d_ctrl = 16'h0001; d_pc = 32'h200;
        #1 check("no_hazard_stall", a_stall, 1'b0);
        tick();
        d_instr = r_add(5'd4, 5'd3, 5'd1); d_ctrl = 16'h0002; d_pc = 32'h204;
        #1 check("lu_stall", a_stall, 1'b1);
        tick();
        check("bubble_valid", a_valid, 1'b0);
        check("bubble_ctrl", a_ctrl, 16'h0);
        check("bubble_stall_clear", a_stall, 1'b0);
        tick();
        check("lu_add_valid", a_valid, 1'b1);
        check("lu_add_rs1", a_rs1, 5'd3);
        check("lu_add_pc", a_pc, 32'h204);
        check("lu_add_stall", a_stall, 1'b0);

        // Flush coincident with load-use
        d_instr = i_lw(5'd3, 5'd1); d_ctrl = 16'h0001; d_pc = 32'h208;
        tick();
        d_instr = r_add(5'd4, 5'd3, 5'd1); d_ctrl = 16'h0002; d_pc = 32'h20C;
        e_flush = 1'b1;
        #1 check("flush_stall", a_stall, 1'b1);
        tick();
        e_flush = 1'b0;
        check("flush_valid", a_valid, 1'b0);
        check("flush_ctrl", a_ctrl, 16'h0);
        check("flush_pc_loaded", a_pc, 32'h20C);

        // Hold for three cycles
        d_instr = r_add(5'd10, 5'd5, 5'd7); d_ctrl = 16'h0008; d_pc = 32'h300;
        tick();
        check("pre_hold_r1", a_r1, 32'hDEADBEEF);
        e_hold = 1'b1;
        d_instr = r_add(5'd11, 5'd7, 5'd5); d_ctrl = 16'h0010; d_pc = 32'h304;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_stall", a_stall, 1'b1);
            tick();
            check("hold_pc", a_pc, 32'h300);
            check("hold_rd", a_rd, 5'd10);
            check("hold_valid", a_valid, 1'b1);
        end

        // Asynchronous reset in the middle of the hold
        #2 rst = 1'b0;
        #1;
        check("arst_valid", a_valid, 1'b0);
        check("arst_pc", a_pc, 32'h0);
        check("arst_r1", a_r1, 32'h0);
        check("arst_ctrl", a_ctrl, 16'h0);
        check("arst_stall_hold", a_stall, 1'b1);
        e_hold = 1'b0;
        #1 check("arst_stall_free", a_stall, 1'b0);
        d_instr = r_add(5'd12, 5'd5, 5'd7); d_ctrl = 16'h0002; d_pc = 32'h400;
        #1 rst = 1'b1;
        tick();
        check("post_rst_valid", a_valid, 1'b1);
        check("post_rst_rd", a_rd, 5'd12);
        check("post_rst_rf_cleared", a_r1, 32'h0);

        // RV32E instance: out-of-range index x20
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'hA5A5A5A5;
        tick();
        wb_rd = 5'd20; wb_data = 32'h5A5A5A5A;
        d_instr = r_add(5'd13, 5'd20, 5'd4);
        #1;
        check("e_illegal", b_ill, 1'b1);
        check("i_legal", a_ill, 1'b0);
        tick();
        check("e_x20_r1", b_r1, 32'h0);
        check("e_x4_r2", b_r2, 32'hA5A5A5A5);
        check("i_x20_bypass", a_r1, 32'h5A5A5A5A);
        wb_we = 1'b0;
        d_instr = r_add(5'd14, 5'd4, 5'd0);
        tick();
        check("e_x4_unchanged", b_r1, 32'hA5A5A5A5);
        d_valid = 1'b0; d_instr = r_add(5'd13, 5'd20, 5'd4);
        #1 check("e_illegal_novalid", b_ill, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
